// File: rtl/idma_dispatch_pkg.sv
// rtl/idma_dispatch_pkg.sv - shared constants, helpers and types for the iDMA channel dispatcher
//
// Contents:
//   MaxChan        largest supported channel count
//   chan_idx_width bits needed to hold a channel index (at least 1)
//   chan_status_t  per-channel status {busy, err}
package idma_dispatch_pkg;

    localparam int MaxChan = 16;

    function automatic int chan_idx_width(input int num_chan);
        return (num_chan > 1) ? $clog2(num_chan) : 1;
    endfunction

    typedef struct packed {
        logic busy;
        logic err;
    } chan_status_t;

endpackage

// File: rtl/idma_dispatch_rr_arb.sv
// rtl/idma_dispatch_rr_arb.sv - round-robin arbiter with registered search pointer
//
// Ports:
//   clk, rst    clock, synchronous active-high reset (pointer returns to 0)
//   req         request mask, one bit per requester
//   en          grant is consumed this cycle; pointer moves past the winner
//   gnt_valid   at least one request present
//   gnt_idx     index of the winning requester
module idma_dispatch_rr_arb #(
    parameter int NumReq = 4,
    parameter int IdxW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] req,
    input  logic              en,
    output logic              gnt_valid,
    output logic [IdxW-1:0]   gnt_idx
);

    // Pointer names the first requester to consider, i.e. one past the last winner.
    logic [IdxW-1:0] ptr;

    always_comb begin
        int idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NumReq; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IdxW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && gnt_valid) begin
            ptr <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
        end
    end

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - synchronous FIFO with registered (non-fall-through) output
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_tdata/in_tvalid/in_tready      write side; in_tready low while full
//   out_tdata/out_tvalid/out_tready   read side; out_tvalid high while non-empty
// Depth must be a power of two; the pointers carry one extra wrap bit.
module stream_fifo #(
    parameter type T     = logic,
    parameter int  Depth = 4
) (
    input  logic clk,
    input  logic rst,
    input  T     in_tdata,
    input  logic in_tvalid,
    output logic in_tready,
    output T     out_tdata,
    output logic out_tvalid,
    input  logic out_tready
);

    localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    T                 mem [Depth];
    logic [AddrW:0]   wr_ptr;
    logic [AddrW:0]   rd_ptr;
    logic             push;
    logic             pop;

    // Full when the addresses match but the wrap bits differ.
    assign in_tready  = !((wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                          (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]));
    assign out_tvalid = (wr_ptr != rd_ptr);
    assign out_tdata  = mem[rd_ptr[AddrW-1:0]];

    assign push = in_tvalid & in_tready;
    assign pop  = out_tvalid & out_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AddrW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AddrW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AddrW-1:0]] <= in_tdata;
    end

endmodule

// File: rtl/idma_multichan_dispatch.sv
// rtl/idma_multichan_dispatch.sv - round-robin dispatcher from N iDMA frontends to one backend
//
// Optional feature macro: IDMA_DISPATCH_ERR_EN (sticky per-channel error flag and masking).
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   chan_req_i/valid_i/ready_o          per-channel job push into a private FIFO
//   chan_done_o                         one-cycle completion pulse per channel
//   chan_busy_o                         queued, held or outstanding work on the channel
//   chan_err_o, chan_err_clr_i          sticky error flag and its clear
//   be_req_o/be_stream_id_o/be_valid_o  request to backend, held while stalled
//   be_ready_i                          backend accepts request
//   be_rsp_valid_i/be_rsp_error_i       in-order completion from backend
//   be_rsp_ready_o                      always 1
module idma_multichan_dispatch
    import idma_dispatch_pkg::*;
#(
    parameter int  NumChan       = 4,
    parameter int  JobFifoDepth  = 4,
    parameter int  InflightDepth = 8,
    parameter int  StreamIdWidth = 4,
    parameter logic [NumChan-1:0][StreamIdWidth-1:0] ChanStreamId = '0,
    parameter type idma_req_t    = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  idma_req_t [NumChan-1:0]  chan_req_i,
    input  logic [NumChan-1:0]       chan_valid_i,
    output logic [NumChan-1:0]       chan_ready_o,
    output logic [NumChan-1:0]       chan_done_o,
    output logic [NumChan-1:0]       chan_busy_o,
    output logic [NumChan-1:0]       chan_err_o,
    input  logic [NumChan-1:0]       chan_err_clr_i,
    output idma_req_t                be_req_o,
    output logic [StreamIdWidth-1:0] be_stream_id_o,
    output logic                     be_valid_o,
    input  logic                     be_ready_i,
    input  logic                     be_rsp_valid_i,
    input  logic                     be_rsp_error_i,
    output logic                     be_rsp_ready_o
);

    localparam int ChanW = chan_idx_width(NumChan);
    localparam int CntW  = $clog2(InflightDepth + 1);

    idma_req_t            fifo_data [NumChan];
    logic [NumChan-1:0]   fifo_valid;
    logic [NumChan-1:0]   fifo_pop;
    logic [NumChan-1:0]   eligible;
    logic [NumChan-1:0]   err_flags;
    logic [NumChan-1:0]   rsp_onehot;
    logic [NumChan-1:0]   done_q;
    chan_status_t [NumChan-1:0] status;

    logic                 gnt_valid;
    logic [ChanW-1:0]     gnt_idx;
    logic                 load_slot;
    logic                 load;

    logic                 hold_valid;
    idma_req_t            hold_req;
    logic [StreamIdWidth-1:0] hold_sid;
    logic [ChanW-1:0]     hold_chan;

    logic                 tag_ready;
    logic                 tag_valid;
    logic [ChanW-1:0]     tag_head;
    logic                 rsp_ok;

    logic [CntW-1:0]      outstanding [NumChan];

    // The tag FIFO full flag is registered, so a pop in this cycle cannot free
    // a slot for a load in the same cycle.
    assign load_slot = (!hold_valid || be_ready_i) && tag_ready;
    assign load      = load_slot && gnt_valid;
    assign rsp_ok    = be_rsp_valid_i && tag_valid;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        stream_fifo #(
            .T     (idma_req_t),
            .Depth (JobFifoDepth)
        ) i_job_fifo (
            .clk        (clk_i),
            .rst        (rst_i),
            .in_tdata   (chan_req_i[c]),
            .in_tvalid  (chan_valid_i[c]),
            .in_tready  (chan_ready_o[c]),
            .out_tdata  (fifo_data[c]),
            .out_tvalid (fifo_valid[c]),
            .out_tready (fifo_pop[c])
        );

        assign fifo_pop[c]   = load && (gnt_idx == ChanW'(c));
        assign rsp_onehot[c] = rsp_ok && (tag_head == ChanW'(c));

        assign status[c].busy = fifo_valid[c] ||
                                (hold_valid && (hold_chan == ChanW'(c))) ||
                                (outstanding[c] != '0);
        assign status[c].err  = err_flags[c];
        assign chan_busy_o[c] = status[c].busy;
        assign chan_err_o[c]  = status[c].err;
    end

`ifdef IDMA_DISPATCH_ERR_EN
    // Set has priority over clear so an error arriving with a clear is not lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_flags <= '0;
        end else begin
            err_flags <= (rsp_onehot & {NumChan{be_rsp_error_i}}) |
                         (err_flags & ~chan_err_clr_i);
        end
    end
    assign eligible = fifo_valid & ~err_flags;
`else
    logic unused_err;
    assign unused_err = ^{be_rsp_error_i, chan_err_clr_i};
    assign err_flags  = '0;
    assign eligible   = fifo_valid;
`endif

    idma_dispatch_rr_arb #(
        .NumReq (NumChan),
        .IdxW   (ChanW)
    ) i_rr_arb (
        .clk       (clk_i),
        .rst       (rst_i),
        .req       (eligible),
        .en        (load_slot),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Tag FIFO records the channel of every loaded job; backend responses are
    // in order, so its head always names the channel of the next completion.
    stream_fifo #(
        .T     (logic [ChanW-1:0]),
        .Depth (InflightDepth)
    ) i_tag_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .in_tdata   (gnt_idx),
        .in_tvalid  (load),
        .in_tready  (tag_ready),
        .out_tdata  (tag_head),
        .out_tvalid (tag_valid),
        .out_tready (be_rsp_valid_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_valid <= 1'b0;
            hold_req   <= '0;
            hold_sid   <= '0;
            hold_chan  <= '0;
            done_q     <= '0;
        end else begin
            if (load) begin
                hold_valid <= 1'b1;
                hold_req   <= fifo_data[gnt_idx];
                hold_sid   <= ChanStreamId[gnt_idx];
                hold_chan  <= gnt_idx;
            end else if (be_ready_i) begin
                hold_valid <= 1'b0;
            end
            done_q <= rsp_onehot;
        end
    end

    // Counted from load (not backend acceptance) to completion; bounded by the
    // tag FIFO depth, so the counters cannot wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NumChan; c++) outstanding[c] <= '0;
        end else begin
            for (int c = 0; c < NumChan; c++) begin
                if (fifo_pop[c] && !rsp_onehot[c]) begin
                    outstanding[c] <= outstanding[c] + CntW'(1);
                end else if (rsp_onehot[c] && !fifo_pop[c]) begin
                    outstanding[c] <= outstanding[c] - CntW'(1);
                end
            end
        end
    end

    rsp_without_job: assert property (@(posedge clk_i) disable iff (rst_i)
        be_rsp_valid_i |-> tag_valid);

    assign be_req_o       = hold_req;
    assign be_stream_id_o = hold_sid;
    assign be_valid_o     = hold_valid;
    assign be_rsp_ready_o = 1'b1;
    assign chan_done_o    = done_q;

endmodule

// File: tb/tb_idma_multichan_dispatch.sv
// tb/tb_idma_multichan_dispatch.sv - self-checking bench for idma_multichan_dispatch
module tb_idma_multichan_dispatch;

    localparam int N  = 4;
    localparam int FD = 4;
    localparam int ID = 8;
    localparam int SW = 4;
`ifdef IDMA_DISPATCH_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef logic [31:0] req_t;

    logic           clk = 1'b0;
    logic           rst;
    req_t [N-1:0]   chan_req;
    logic [N-1:0]   chan_valid;
    logic [N-1:0]   chan_ready_o;
    logic [N-1:0]   chan_done_o;
    logic [N-1:0]   chan_busy_o;
    logic [N-1:0]   chan_err_o;
    logic [N-1:0]   chan_err_clr;
    req_t           be_req_o;
    logic [SW-1:0]  be_stream_id_o;
    logic           be_valid_o;
    logic           be_ready;
    logic           be_rsp_valid;
    logic           be_rsp_error;
    logic           be_rsp_ready_o;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    // Behavioural model: queues of jobs per channel, one output slot, an
    // in-order list of dispatched channels and per-channel outstanding counts.
    req_t mq [N][$];
    bit   m_hold_v;
    req_t m_hold_req;
    int   m_hold_chan;
    int   m_tags[$];
    int   m_out [N];
    bit   m_err [N];
    int   m_rr;
    logic [N-1:0] m_done;
    int   be_pending;

    int   issued[$];
    int   dones[$];

    idma_multichan_dispatch #(
        .NumChan       (N),
        .JobFifoDepth  (FD),
        .InflightDepth (ID),
        .StreamIdWidth (SW),
        .ChanStreamId  ({4'h3, 4'h5, 4'hA, 4'h1}),
        .idma_req_t    (req_t)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .chan_req_i     (chan_req),
        .chan_valid_i   (chan_valid),
        .chan_ready_o   (chan_ready_o),
        .chan_done_o    (chan_done_o),
        .chan_busy_o    (chan_busy_o),
        .chan_err_o     (chan_err_o),
        .chan_err_clr_i (chan_err_clr),
        .be_req_o       (be_req_o),
        .be_stream_id_o (be_stream_id_o),
        .be_valid_o     (be_valid_o),
        .be_ready_i     (be_ready),
        .be_rsp_valid_i (be_rsp_valid),
        .be_rsp_error_i (be_rsp_error),
        .be_rsp_ready_o (be_rsp_ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] sid_of(input int c);
        case (c)
            0:       return 4'h1;
            1:       return 4'hA;
            2:       return 4'h5;
            default: return 4'h3;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int           g;
        bit           slot;
        bit           pre_ready [N];
        logic [N-1:0] nd;
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                mq[c].delete();
                m_out[c] = 0;
                m_err[c] = 1'b0;
            end
            m_tags.delete();
            m_hold_v   = 1'b0;
            m_hold_req = '0;
            m_hold_chan = 0;
            m_rr       = 0;
            m_done     = '0;
            be_pending = 0;
            return;
        end
        for (int c = 0; c < N; c++) pre_ready[c] = (mq[c].size() < FD);
        slot = (!m_hold_v || be_ready) && (m_tags.size() < ID);
        g = -1;
        if (slot) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_rr + i) % N;
                if (g < 0 && mq[c].size() > 0 && !(ErrEn && m_err[c])) g = c;
            end
        end
        if (m_hold_v && be_ready) be_pending++;
        if (be_rsp_valid) be_pending--;
        nd = '0;
        if (be_rsp_valid && m_tags.size() > 0) begin
            int t;
            t = m_tags.pop_front();
            nd[t] = 1'b1;
            m_out[t]--;
        end
        if (ErrEn) begin
            for (int c = 0; c < N; c++)
                m_err[c] = (nd[c] && be_rsp_error) || (m_err[c] && !chan_err_clr[c]);
        end
        m_done = nd;
        if (g >= 0) begin
            m_hold_v    = 1'b1;
            m_hold_req  = mq[g].pop_front();
            m_hold_chan = g;
            m_tags.push_back(g);
            m_out[g]++;
            m_rr = (g + 1) % N;
        end else if (be_ready) begin
            m_hold_v = 1'b0;
        end
        for (int c = 0; c < N; c++)
            if (chan_valid[c] && pre_ready[c]) mq[c].push_back(chan_req[c]);
    endtask

    logic [N-1:0] e_ready, e_busy, e_err;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < N; c++) begin
                e_ready[c] = (mq[c].size() < FD);
                e_busy[c]  = (mq[c].size() > 0) || (m_hold_v && m_hold_chan == c) || (m_out[c] != 0);
                e_err[c]   = m_err[c];
            end
            check("chan_ready", chan_ready_o, e_ready);
            check("chan_busy", chan_busy_o, e_busy);
            check("chan_err", chan_err_o, e_err);
            check("chan_done", chan_done_o, m_done);
            check("be_valid", be_valid_o, m_hold_v);
            check("be_rsp_ready", be_rsp_ready_o, 1'b1);
            if (m_hold_v) begin
                check("be_req", be_req_o, m_hold_req);
                check("be_stream_id", be_stream_id_o, sid_of(m_hold_chan));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        chan_valid   = '0;
        chan_req     = '0;
        chan_err_clr = '0;
        be_ready     = 1'b0;
        be_rsp_valid = 1'b0;
        be_rsp_error = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        issued.delete();
        dones.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check({tag, "_ready"}, chan_ready_o, 4'hF);
        check({tag, "_busy"}, chan_busy_o, 4'h0);
        check({tag, "_done"}, chan_done_o, 4'h0);
        check({tag, "_err"}, chan_err_o, 4'h0);
        check({tag, "_be_valid"}, be_valid_o, 1'b0);
        check({tag, "_be_req"}, be_req_o, 32'h0);
        check({tag, "_be_sid"}, be_stream_id_o, 4'h0);
    endtask

    task automatic run_obs(input int n, input logic [N-1:0] mask, input int push_n,
                           input bit auto_rsp, input bit rsp_err);
        for (int k = 0; k < n; k++) begin
            chan_valid = (k < push_n) ? mask : '0;
            for (int c = 0; c < N; c++) chan_req[c] = {8'(c), 8'hA5, 16'(k)};
            be_rsp_valid = auto_rsp && (be_pending > 0);
            be_rsp_error = rsp_err;
            @(negedge clk);
            if (be_valid_o && be_ready) issued.push_back(int'(be_req_o[31:24]));
            for (int c = 0; c < N; c++) if (chan_done_o[c]) dones.push_back(c);
            tick();
        end
        chan_valid   = '0;
        be_rsp_valid = 1'b0;
        be_rsp_error = 1'b0;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;

        // Reset values
        do_reset();
        check_reset_vals("rst0");

        // Single job on ch2: valid two cycles after acceptance, done one after response
        be_ready    = 1'b1;
        chan_valid  = 4'b0100;
        chan_req[2] = 32'hCAFE_0002;
        tick();
        chan_valid = '0;
        @(negedge clk);
        check("t1_valid_t1", be_valid_o, 1'b0);
        tick();
        @(negedge clk);
        check("t1_valid_t2", be_valid_o, 1'b1);
        check("t1_sid", be_stream_id_o, 4'h5);
        check("t1_req", be_req_o, 32'hCAFE_0002);
        tick();
        be_rsp_valid = 1'b1;
        @(negedge clk);
        check("t1_done_early", chan_done_o, 4'b0000);
        tick();
        be_rsp_valid = 1'b0;
        @(negedge clk);
        check("t1_done", chan_done_o, 4'b0100);
        tick();
        @(negedge clk);
        check("t1_done_clear", chan_done_o, 4'b0000);

        // All channels submit 3 jobs: round-robin issue and completion order
        do_reset();
        be_ready = 1'b1;
        run_obs(40, 4'hF, 3, 1'b1, 1'b0);
        check("rr_issue_count", issued.size(), 12);
        check("rr_done_count", dones.size(), 12);
        for (int i = 0; i < 12 && i < issued.size(); i++) check("rr_issue_order", issued[i], i % 4);
        for (int i = 0; i < 12 && i < dones.size(); i++) check("rr_done_order", dones[i], i % 4);

        // Backend stalled: request stays put and channel FIFOs fill
        do_reset();
        be_ready = 1'b0;
        run_obs(20, 4'hF, 20, 1'b0, 1'b0);
        @(negedge clk);
        check("stall_valid", be_valid_o, 1'b1);
        check("stall_req", be_req_o, 32'h00A5_0000);
        check("stall_sid", be_stream_id_o, 4'h1);
        check("stall_ready", chan_ready_o, 4'b0000);
        check("stall_issued", issued.size(), 0);

        // In-flight bound: ch0 floods with no responses
        do_reset();
        be_ready = 1'b1;
        run_obs(30, 4'b0001, 30, 1'b0, 1'b0);
        @(negedge clk);
        check("flood_inflight", issued.size(), 8);
        check("flood_valid", be_valid_o, 1'b0);
        check("flood_ready", chan_ready_o, 4'b1110);
        be_rsp_valid = 1'b1;
        tick();
        be_rsp_valid = 1'b0;
        run_obs(10, 4'b0001, 10, 1'b0, 1'b0);
        check("flood_one_more", issued.size(), 9);
        check("flood_done", dones.size(), 1);

`ifdef IDMA_DISPATCH_ERR_EN
        // Error on ch1 masks it; ch3 proceeds; clear resumes ch1
        do_reset();
        be_ready = 1'b1;
        run_obs(8, 4'b0010, 1, 1'b1, 1'b1);
        check("err_flag", chan_err_o, 4'b0010);
        check("err_done", dones.size(), 1);
        issued.delete();
        run_obs(12, 4'b1010, 2, 1'b1, 1'b0);
        check("err_masked_count", issued.size(), 2);
        for (int i = 0; i < issued.size(); i++) check("err_masked_chan", issued[i], 3);
        check("err_ch1_busy", chan_busy_o[1], 1'b1);
        check("err_still_set", chan_err_o, 4'b0010);
        issued.delete();
        chan_err_clr = 4'b0010;
        tick();
        chan_err_clr = '0;
        run_obs(10, 4'b0000, 0, 1'b1, 1'b0);
        check("err_resume_count", issued.size(), 2);
        for (int i = 0; i < issued.size(); i++) check("err_resume_chan", issued[i], 1);
        check("err_cleared", chan_err_o, 4'b0000);
`endif

        // Reset with 5 jobs in flight
        do_reset();
        be_ready = 1'b1;
        run_obs(8, 4'b0001, 5, 1'b0, 1'b0);
        @(negedge clk);
        check("inflight_busy", chan_busy_o, 4'b0001);
        check("inflight_issued", issued.size(), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("rst_mid");

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            chan_valid = N'($urandom);
            for (int c = 0; c < N; c++) chan_req[c] = {8'(c), 8'($urandom), 16'(k)};
            be_ready     = ($urandom_range(0, 3) != 0);
            be_rsp_valid = (be_pending > 0) &&
                           ((k < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0));
            be_rsp_error = ($urandom_range(0, 7) == 0);
            chan_err_clr = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            tick();
        end
        set_idle();
        tick();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
